cell_test_sequencer: RTL and testbench



---
 rtl/cell_test_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_cell_test_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_test_sequencer.sv
// cell_test_sequencer: sweeps every input pattern over a bank of cells under
// test, waits a settle interval, samples each synchronised cell output and
// compares it against a per-cell truth table, accumulating pass/fail results.
// Ports:
//   wb_clk_i, wb_rst_ni     clock, synchronous active-low reset
//   start_i, stop_i, loop_i sweep control (loop_i latched at accepted start)
//   cell_en_i               per-cell compare enable
//   resp_i                  asynchronous cell outputs
//   stim_o                  pattern broadcast to all cell inputs
//   busy_o, done_o          sweep in progress / sticky single-pass complete
//   fail_o                  sticky per-cell mismatch flags
//   err_cnt_o, pass_cnt_o   saturating mismatch count / wrapping pass count
// Optional macro CELL_SEQ_FIRST_FAIL_EN adds first_fail_vld_o,
// first_fail_pat_o and first_fail_cell_o (first mismatch after start).
module cell_test_sequencer #(
    parameter int N_CELLS       = 11,
    parameter int MAX_IN        = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 16,
    parameter logic [N_CELLS*(2**MAX_IN)-1:0] TRUTH_TABLE = '0,
    localparam int CELL_W = (N_CELLS > 1) ? $clog2(N_CELLS) : 1
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               loop_i,
    input  logic [N_CELLS-1:0] cell_en_i,
    input  logic [N_CELLS-1:0] resp_i,
    output logic [MAX_IN-1:0]  stim_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [N_CELLS-1:0] fail_o,
    output logic [ERR_W-1:0]   err_cnt_o,
    output logic [15:0]        pass_cnt_o
`ifdef CELL_SEQ_FIRST_FAIL_EN
    ,
    output logic               first_fail_vld_o,
    output logic [MAX_IN-1:0]  first_fail_pat_o,
    output logic [CELL_W-1:0]  first_fail_cell_o
`endif
);

    localparam int NPAT  = 2**MAX_IN;
    localparam int CNT_W = $clog2(SETTLE_CYCLES);
    localparam int SUM_W = ERR_W + 7;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MAX_IN-1:0]  pat_q, pat_d;
    logic               loop_q, loop_d;
    logic               done_q, done_d;
    logic [N_CELLS-1:0] fail_q, fail_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [15:0]        pass_q, pass_d;
    logic [N_CELLS-1:0] sync1_q, sync2_q;

    logic [N_CELLS-1:0] exp_v;
    logic [N_CELLS-1:0] mism;
    logic [5:0]         nmis;
    logic [SUM_W-1:0]   err_sum;
    logic [ERR_W-1:0]   err_sat;
    logic               accept;
    logic               smp;

    // Each cell's row of the truth table is a constant; only the pattern
    // selects a bit at run time.
    for (genvar g = 0; g < N_CELLS; g++) begin : g_exp
        localparam logic [NPAT-1:0] ROW = TRUTH_TABLE[g*NPAT +: NPAT];
        assign exp_v[g] = ROW[pat_q];
    end

    assign accept = (state_q == IDLE) && start_i && !stop_i;
    assign smp    = (state_q == SAMPLE) && !stop_i;

    always_comb begin
        nmis = '0;
        mism = (sync2_q ^ exp_v) & cell_en_i;
        for (int c = 0; c < N_CELLS; c++) begin
            nmis = nmis + 6'(mism[c]);
        end
        err_sum = SUM_W'(err_q) + SUM_W'(nmis);
        err_sat = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX
                                               : err_sum[ERR_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        loop_d  = loop_q;
        done_d  = done_q;
        fail_d  = fail_q;
        err_d   = err_q;
        pass_d  = pass_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                    pat_d   = '0;
                    loop_d  = loop_i;
                    done_d  = 1'b0;
                    fail_d  = '0;
                    err_d   = '0;
                    pass_d  = '0;
                end
            end
            SETTLE: begin
                if (stop_i) begin
                    state_d = IDLE;
                    pat_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                cnt_d = '0;
                if (stop_i) begin
                    // Abort skips this cycle's compare.
                    state_d = IDLE;
                    pat_d   = '0;
                end else begin
                    fail_d = fail_q | mism;
                    err_d  = err_sat;
                    if (pat_q != '1) begin
                        pat_d   = pat_q + MAX_IN'(1);
                        state_d = SETTLE;
                    end else begin
                        pass_d = pass_q + 16'd1;
                        pat_d  = '0;
                        if (loop_q) begin
                            state_d = SETTLE;
                        end else begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pat_d   = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pat_q   <= '0;
            loop_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= '0;
            err_q   <= '0;
            pass_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            loop_q  <= loop_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            sync1_q <= resp_i;
            sync2_q <= sync1_q;
        end
    end

    // Pattern register is held at zero outside a sweep, so it drives stim_o.
    assign stim_o     = pat_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign fail_o     = fail_q;
    assign err_cnt_o  = err_q;
    assign pass_cnt_o = pass_q;

`ifdef CELL_SEQ_FIRST_FAIL_EN
    logic              ffv_q, ffv_d;
    logic [MAX_IN-1:0] ffp_q, ffp_d;
    logic [CELL_W-1:0] ffc_q, ffc_d;
    logic [CELL_W-1:0] first_c;

    // Descending scan so the lowest-index mismatching cell wins.
    always_comb begin
        first_c = '0;
        for (int c = N_CELLS - 1; c >= 0; c--) begin
            if (mism[c]) first_c = CELL_W'(c);
        end
    end

    always_comb begin
        ffv_d = ffv_q;
        ffp_d = ffp_q;
        ffc_d = ffc_q;
        if (accept) begin
            ffv_d = 1'b0;
            ffp_d = '0;
            ffc_d = '0;
        end else if (smp && !ffv_q && (|mism)) begin
            ffv_d = 1'b1;
            ffp_d = pat_q;
            ffc_d = first_c;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            ffv_q <= 1'b0;
            ffp_q <= '0;
            ffc_q <= '0;
        end else begin
            ffv_q <= ffv_d;
            ffp_q <= ffp_d;
            ffc_q <= ffc_d;
        end
    end

    assign first_fail_vld_o  = ffv_q;
    assign first_fail_pat_o  = ffp_q;
    assign first_fail_cell_o = ffc_q;
`endif

endmodule

// File: tb/tb_cell_test_sequencer.sv
// tb_cell_test_sequencer: directed sweeps against two sequencer instances
// (ERR_W=4 and ERR_W=16) with a scoreboard checked at the end of every sweep.
module tb_cell_test_sequencer;

    typedef struct {
        logic [10:0] fail;
        int          err_a;
        int          err_b;
        int          pass;
        logic        done;
        int          len;
        logic        ffv;
        int          ffp;
        int          ffc;
    } exp_t;

    // Cell models: INV, AND2, OR2, OR3, AND3, repeating.
    function automatic logic golden(int c, logic [2:0] q);
        logic r;
        r = 1'b0;
        case (c % 5)
            0: r = ~q[0];
            1: r = q[0] & q[1];
            2: r = q[0] | q[1];
            3: r = |q;
            default: r = &q;
        endcase
        return r;
    endfunction

    function automatic logic [87:0] build_tt();
        logic [87:0] t;
        t = '0;
        for (int c = 0; c < 11; c++)
            for (int p = 0; p < 8; p++)
                t[c*8+p] = golden(c, 3'(p));
        return t;
    endfunction

    // mode 0: correct, 1: cell 4 stuck at 1, 2: all outputs inverted
    function automatic logic [10:0] resp_model(logic [2:0] s, int m);
        logic [10:0] r;
        r = '0;
        for (int c = 0; c < 11; c++) begin
            r[c] = golden(c, s);
            if (m == 1 && c == 4) r[c] = 1'b1;
            if (m == 2) r[c] = ~r[c];
        end
        return r;
    endfunction

    localparam logic [87:0] TT = build_tt();

    logic        clk;
    logic        rst_n;
    logic        start, stop, loop_m;
    logic [10:0] cell_en;
    logic [10:0] resp_a, resp_b;
    logic [2:0]  stim_a, stim_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [10:0] fail_a, fail_b;
    logic [3:0]  err_a;
    logic [15:0] err_b;
    logic [15:0] pass_a, pass_b;
    int          mode;
`ifdef CELL_SEQ_FIRST_FAIL_EN
    logic        ffv_a, ffv_b;
    logic [2:0]  ffp_a, ffp_b;
    logic [3:0]  ffc_a, ffc_b;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always_comb resp_a = resp_model(stim_a, mode);
    always_comb resp_b = resp_model(stim_b, mode);

    cell_test_sequencer #(
        .N_CELLS(11), .MAX_IN(3), .SETTLE_CYCLES(4), .ERR_W(4),
        .TRUTH_TABLE(TT)
    ) dut_a (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .start_i(start), .stop_i(stop), .loop_i(loop_m),
        .cell_en_i(cell_en), .resp_i(resp_a),
        .stim_o(stim_a), .busy_o(busy_a), .done_o(done_a),
        .fail_o(fail_a), .err_cnt_o(err_a), .pass_cnt_o(pass_a)
`ifdef CELL_SEQ_FIRST_FAIL_EN
        , .first_fail_vld_o(ffv_a), .first_fail_pat_o(ffp_a),
        .first_fail_cell_o(ffc_a)
`endif
    );

    cell_test_sequencer #(
        .N_CELLS(11), .MAX_IN(3), .SETTLE_CYCLES(4), .ERR_W(16),
        .TRUTH_TABLE(TT)
    ) dut_b (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .start_i(start), .stop_i(stop), .loop_i(loop_m),
        .cell_en_i(cell_en), .resp_i(resp_b),
        .stim_o(stim_b), .busy_o(busy_b), .done_o(done_b),
        .fail_o(fail_b), .err_cnt_o(err_b), .pass_cnt_o(pass_b)
`ifdef CELL_SEQ_FIRST_FAIL_EN
        , .first_fail_vld_o(ffv_b), .first_fail_pat_o(ffp_b),
        .first_fail_cell_o(ffc_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Monitor: checks the pattern step while busy; when busy falls, pops
    // the expected end-of-sweep state and compares.
    initial begin : monitor
        int   blen;
        logic prev;
        exp_t e;
        blen = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_a === 1'b1) begin
                chk("stim_step", 64'(stim_a), 64'((blen / 5) % 8));
                chk("busy_match", 64'(busy_b), 64'(1));
                blen++;
            end else if (prev) begin
                if (sb.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL sb_empty actual=0 required=1");
                end else begin
                    e = sb.pop_front();
                    chk("busy_len", 64'(blen), 64'(e.len));
                    chk("fail_a", 64'(fail_a), 64'(e.fail));
                    chk("fail_b", 64'(fail_b), 64'(e.fail));
                    chk("err_a", 64'(err_a), 64'(e.err_a));
                    chk("err_b", 64'(err_b), 64'(e.err_b));
                    chk("pass_a", 64'(pass_a), 64'(e.pass));
                    chk("pass_b", 64'(pass_b), 64'(e.pass));
                    chk("done_a", 64'(done_a), 64'(e.done));
                    chk("done_b", 64'(done_b), 64'(e.done));
                    chk("stim_idle", 64'(stim_a), 64'(0));
                    chk("busy_b_low", 64'(busy_b), 64'(0));
`ifdef CELL_SEQ_FIRST_FAIL_EN
                    chk("ff_vld_a", 64'(ffv_a), 64'(e.ffv));
                    chk("ff_pat_a", 64'(ffp_a), 64'(e.ffp));
                    chk("ff_cell_a", 64'(ffc_a), 64'(e.ffc));
                    chk("ff_vld_b", 64'(ffv_b), 64'(e.ffv));
                    chk("ff_cell_b", 64'(ffc_b), 64'(e.ffc));
`endif
                end
                blen = 0;
            end
            prev = busy_a;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_a === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(n >= 400), 64'(0));
        @(negedge clk);
    endtask

    task automatic launch(int m, logic [10:0] en, logic lp, exp_t e);
        mode    = m;
        cell_en = en;
        loop_m  = lp;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_single(int m, logic [10:0] en, exp_t e);
        launch(m, en, 1'b0, e);
        // A start pulse mid-sweep must be ignored.
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        loop_m  = 1'b0;
        cell_en = '1;
        mode    = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy_a), 64'(0));
        chk("rst_done", 64'(done_a), 64'(0));
        chk("rst_fail", 64'(fail_a), 64'(0));
        chk("rst_err", 64'(err_a), 64'(0));
        chk("rst_pass", 64'(pass_a), 64'(0));
        chk("rst_stim", 64'(stim_a), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run_single(0, 11'h7FF, '{11'h000, 0, 0, 1, 1'b1, 40, 1'b0, 0, 0});

        // start and stop together in IDLE: nothing happens
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_busy", 64'(busy_a), 64'(0));
        chk("ss_done", 64'(done_a), 64'(1));
        chk("ss_pass", 64'(pass_a), 64'(1));
        @(negedge clk);
        chk("ss_busy2", 64'(busy_a), 64'(0));

        run_single(1, 11'h7FF, '{11'h010, 7, 7, 1, 1'b1, 40, 1'b1, 0, 4});
        run_single(1, 11'h7EF, '{11'h000, 0, 0, 1, 1'b1, 40, 1'b0, 0, 0});
        run_single(2, 11'h7FF, '{11'h7FF, 15, 88, 1, 1'b1, 40, 1'b1, 0, 0});

        // continuous mode, stop seen at edge 95
        launch(0, 11'h7FF, 1'b1, '{11'h000, 0, 0, 2, 1'b0, 95, 1'b0, 0, 0});
        repeat (94) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle();

        // reset during pattern 3 (edge 17)
        launch(2, 11'h7FF, 1'b0, '{11'h000, 0, 0, 0, 1'b0, 17, 1'b0, 0, 0});
        repeat (16) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle();

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
